// File: rtl/mux_sel_arbiter_if.sv
// Requester/arbiter bundle for mux_sel_arbiter: level requests in, one-hot
// grant, mux select and grant status out.
interface mux_sel_arbiter_if #(
    parameter int CNT_W = 5
);
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [1:0]       select;
    logic             sel_valid;
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout;

    modport master (
        input  req,
        output gnt,
        output select,
        output sel_valid,
        output hold_cnt,
        output timeout
    );

    modport slave (
        output req,
        input  gnt,
        input  select,
        input  sel_valid,
        input  hold_cnt,
        input  timeout
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the 4:1 mux select with dwell limit and a guard cycle.
// Optional fixed priority/preemption for requester 0: define MUX_ARB_PRIO_EN.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux_sel_arbiter_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t           state_r;
    logic [1:0]       last_r;
    logic [3:0]       gnt_r;
    logic [1:0]       select_r;
    logic             sel_valid_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic             timeout_r;

    logic [2:0]       pick_s;
    logic             owner_req_s;
    logic             at_max_s;
    logic             preempt_s;
    logic             release_s;

    // Returns {found, index}; search order is last+1, last+2, last+3, last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = last + 2'(k) + 2'd1;
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
`ifdef MUX_ARB_PRIO_EN
        if (r[0]) begin
            res = {1'b1, 2'b00};
        end else begin
            res = res;
        end
`endif
        return res;
    endfunction

    // Arbitration winner and grant-termination conditions for this edge.
    always_comb begin
        pick_s      = rr_pick(bus.req, last_r);
        owner_req_s = bus.req[select_r];
        at_max_s    = (hold_cnt_r == CNT_W'(MAX_HOLD));
`ifdef MUX_ARB_PRIO_EN
        preempt_s   = (select_r != 2'b00) && bus.req[0];
`else
        preempt_s   = 1'b0;
`endif
        release_s   = !owner_req_s || at_max_s || preempt_s;
    end

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_r      <= 2'd3;
            gnt_r       <= 4'b0000;
            select_r    <= 2'b00;
            sel_valid_r <= 1'b0;
            hold_cnt_r  <= '0;
            timeout_r   <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE, GUARD: begin
                    // select only moves on the edge that raises sel_valid
                    if (pick_s[2]) begin
                        state_r     <= GRANT;
                        gnt_r       <= 4'b0001 << pick_s[1:0];
                        select_r    <= pick_s[1:0];
                        sel_valid_r <= 1'b1;
                        hold_cnt_r  <= CNT_W'(1);
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_r     <= GUARD;
                        gnt_r       <= 4'b0000;
                        sel_valid_r <= 1'b0;
                        hold_cnt_r  <= '0;
                        last_r      <= select_r;
                        timeout_r   <= at_max_s && owner_req_s;
                    end else begin
                        hold_cnt_r  <= hold_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    gnt_r       <= 4'b0000;
                    sel_valid_r <= 1'b0;
                    hold_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.select    = select_r;
    assign bus.sel_valid = sel_valid_r;
    assign bus.hold_cnt  = hold_cnt_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboarded bench for mux_sel_arbiter: two instances (MAX_HOLD 4 and 1)
// share one request stream and are compared against a behavioural model.
module tb_mux_sel_arbiter;

    localparam int MH4 = 4;
    localparam int CW4 = $clog2(MH4 + 1);
    localparam int MH1 = 1;
    localparam int CW1 = $clog2(MH1 + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    mux_sel_arbiter_if #(.CNT_W(CW4)) bus4 ();
    mux_sel_arbiter_if #(.CNT_W(CW1)) bus1 ();

    assign bus4.req = req;
    assign bus1.req = req;

    mux_sel_arbiter #(.MAX_HOLD(MH4), .CNT_W(CW4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux_sel_arbiter #(.MAX_HOLD(MH1), .CNT_W(CW1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    typedef struct {
        int   owner;   // -1 when nobody holds the mux
        int   dwell;
        int   last;
        int   sel;
        logic to;
    } mst_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       v;
        int         hc;
        logic       to;
        int         cyc;
    } exp_t;

    mst_t ms4, ms1;
    exp_t q4[$];
    exp_t q1[$];

    function automatic mst_t minit();
        mst_t s;
        s.owner = -1; s.dwell = 0; s.last = 3; s.sel = 0; s.to = 1'b0;
        return s;
    endfunction

    // One clock of the arbitration rules applied to the requests seen at the edge.
    function automatic mst_t mstep(mst_t s, logic [3:0] r, int maxh);
        mst_t n;
        bit   keep, full, pre;
        int   w, idx;
        n = s;
        n.to = 1'b0;
        if (s.owner >= 0) begin
            keep = r[s.owner];
            full = (s.dwell >= maxh);
            pre  = 1'b0;
`ifdef MUX_ARB_PRIO_EN
            pre  = (s.owner != 0) && r[0];
`endif
            if (!keep || full || pre) begin
                n.to    = full && keep;
                n.last  = s.owner;
                n.owner = -1;
                n.dwell = 0;
            end else begin
                n.dwell = s.dwell + 1;
            end
        end else begin
            w = -1;
            for (int k = 4; k >= 1; k--) begin
                idx = (s.last + k) % 4;
                if (r[idx]) w = idx;
            end
`ifdef MUX_ARB_PRIO_EN
            if (r[0]) w = 0;
`endif
            if (w >= 0) begin
                n.owner = w;
                n.sel   = w;
                n.dwell = 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t toexp(mst_t s, int c);
        exp_t e;
        e.gnt = (s.owner >= 0) ? 4'(1 << s.owner) : 4'b0000;
        e.sel = 2'(s.sel);
        e.v   = (s.owner >= 0);
        e.hc  = s.dwell;
        e.to  = s.to;
        e.cyc = c;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [3:0] g, input logic [1:0] s,
                       input logic v, input logic [7:0] hc, input logic to);
        checks++;
        if (g !== e.gnt || s !== e.sel || v !== e.v || int'(hc) != e.hc || to !== e.to) begin
            errors++;
            $display("FAIL %s cycle %0d: got gnt=%b sel=%0d valid=%b hold=%0d timeout=%b, expected gnt=%b sel=%0d valid=%b hold=%0d timeout=%b",
                     nm, e.cyc, g, s, v, hc, to, e.gnt, e.sel, e.v, e.hc, e.to);
        end
    endtask

    // Monitor: pops one expected record per instance each cycle, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            cmp("scoreboard_mh4", e, bus4.gnt, bus4.select, bus4.sel_valid, 8'(bus4.hold_cnt), bus4.timeout);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("scoreboard_mh1", e, bus1.gnt, bus1.select, bus1.sel_valid, 8'(bus1.hold_cnt), bus1.timeout);
        end
    end

    // Drive r for the next edge, clock it, and predict the post-edge outputs.
    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
        cyc_n++;
        ms4 = mstep(ms4, req, MH4);
        ms1 = mstep(ms1, req, MH1);
        q4.push_back(toexp(ms4, cyc_n));
        q1.push_back(toexp(ms1, cyc_n));
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock.
    task automatic do_reset(input logic [3:0] rel_req);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt",       32'(bus4.gnt),       32'h0);
        chk("rst_select",    32'(bus4.select),    32'h0);
        chk("rst_sel_valid", 32'(bus4.sel_valid), 32'h0);
        chk("rst_hold_cnt",  32'(bus4.hold_cnt),  32'h0);
        chk("rst_timeout",   32'(bus4.timeout),   32'h0);
        chk("rst_gnt_mh1",   32'(bus1.gnt),       32'h0);
        req = rel_req;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ms4 = minit();
        ms1 = minit();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        ms4 = minit();
        ms1 = minit();
        do_reset(4'b0000);

        // Single request, grant, drop, guard then idle.
        cyc(4'b0001);
        chk("t1_gnt", 32'(bus4.gnt), 32'h1);
        chk("t1_select", 32'(bus4.select), 32'h0);
        chk("t1_valid", 32'(bus4.sel_valid), 32'h1);
        chk("t1_hold", 32'(bus4.hold_cnt), 32'h1);
        cyc(4'b0000);
        chk("t1_guard_gnt", 32'(bus4.gnt), 32'h0);
        chk("t1_guard_valid", 32'(bus4.sel_valid), 32'h0);
        cyc(4'b0000);
        cyc(4'b0000);

        // All requesting: rotation 0,1,2,3,0 with a timeout in every guard cycle.
        do_reset(4'b0000);
        for (int i = 1; i <= 25; i++) begin
            cyc(4'b1111);
            if (i % 5 == 1) chk("t2_rotation_gnt", 32'(bus4.gnt), 32'(4'b0001 << ((i / 5) % 4)));
            if (i % 5 == 0) chk("t2_guard_timeout", 32'(bus4.timeout), 32'h1);
            if (i % 5 == 4) chk("t2_hold_at_max", 32'(bus4.hold_cnt), 32'(MH4));
        end

        // Wrap from owner 3 back to 0.
        do_reset(4'b0000);
        cyc(4'b1000);
        for (int i = 0; i < 4; i++) cyc(4'b1001);
        chk("t3_wrap_timeout", 32'(bus4.timeout), 32'h1);
        cyc(4'b1001);
        chk("t3_wrap_gnt", 32'(bus4.gnt), 32'h1);
        chk("t3_wrap_select", 32'(bus4.select), 32'h0);

        // Reset in the middle of owner 2's grant.
        do_reset(4'b0000);
        cyc(4'b0100);
        cyc(4'b0100);
        chk("t4_pre_gnt", 32'(bus4.gnt), 32'h4);
        do_reset(4'b0100);
        cyc(4'b0100);
        chk("t4_after_gnt", 32'(bus4.gnt), 32'h4);

        // Requester 0 arriving while owner 2 holds the mux.
        do_reset(4'b0000);
        cyc(4'b0100);
        cyc(4'b0100);
`ifdef MUX_ARB_PRIO_EN
        cyc(4'b0101);
        chk("t5_preempt_gnt", 32'(bus4.gnt), 32'h0);
        chk("t5_preempt_timeout", 32'(bus4.timeout), 32'h0);
        cyc(4'b0101);
        chk("t5_prio_gnt", 32'(bus4.gnt), 32'h1);
`else
        cyc(4'b0101);
        chk("t5_hold3", 32'(bus4.hold_cnt), 32'h3);
        cyc(4'b0101);
        cyc(4'b0101);
        chk("t5_timeout", 32'(bus4.timeout), 32'h1);
        cyc(4'b1101);
        chk("t5_next_gnt", 32'(bus4.gnt), 32'h8);
`endif

        // MAX_HOLD=1 instance: one on, one off, select fixed at 1.
        do_reset(4'b0000);
        for (int i = 1; i <= 6; i++) begin
            cyc(4'b0010);
            chk("t6_gnt", 32'(bus1.gnt), (i % 2 == 1) ? 32'h2 : 32'h0);
            chk("t6_timeout", 32'(bus1.timeout), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t6_select", 32'(bus1.select), 32'h1);
        end

        // Random request traffic with sticky levels and occasional resets.
        do_reset(4'b0000);
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            if (i % 700 == 699) do_reset(r);
            cyc(r);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 32'(q4.size() + q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
